// File: rtl/inst_fetch_resp.sv
// Instruction fetch response stage: issues one aligned memory read per accepted PC and returns the instruction.
// Latency: request registered 1 cycle after acceptance; instruction valid 1 cycle after mem_ack_i.
// Backpressure: busy_o holds off the PC generator until idle; stall_i holds the instruction in HOLD.
// Optional: define FETCH_TIMEOUT_EN to abort a WAIT that sees no acknowledge within TIMEOUT cycles.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module inst_fetch_resp #(
  parameter int TIMEOUT = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [`ADDR_WIDTH-1:0] pc_i,
  input  logic                   ce_i,
  output logic                   busy_o,
  input  logic                   flush_i,
  input  logic                   stall_i,
  output logic                   mem_req_o,
  output logic [`ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [31:0]            mem_rdata_i,
  input  logic                   mem_ack_i,
  output logic [31:0]            inst_o,
  output logic [`ADDR_WIDTH-1:0] inst_addr_o,
  output logic                   inst_valid_o,
  output logic                   fetch_err_o
);

  // A zero or negative abort window would make every fetch fail.
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("inst_fetch_resp: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic                     drop;
  logic                     drop_nxt;
  logic                     req_nxt;
  logic [`ADDR_WIDTH-1:0]   addr_nxt;
  logic [31:0]              inst_nxt;
  logic [`ADDR_WIDTH-1:0]   inst_addr_nxt;
  logic                     valid_nxt;
  logic                     err_nxt;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          timeout_hit;

  // The current WAIT cycle is the TIMEOUT-th one without an acknowledge.
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
`endif

  // Busy comes straight from the state register so it never depends on this cycle's inputs.
  assign busy_o = (state != IDLE);

  // Next-state and next-output decode; every register holds its value unless a branch says otherwise.
  always_comb begin
    state_nxt     = state;
    drop_nxt      = drop;
    req_nxt       = mem_req_o;
    addr_nxt      = mem_addr_o;
    inst_nxt      = inst_o;
    inst_addr_nxt = inst_addr_o;
    valid_nxt     = inst_valid_o;
    err_nxt       = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_nxt       = cnt;
`endif
    case (state)
      IDLE: begin
        // The valid pulse of a non-stalled instruction lasts exactly one cycle.
        valid_nxt = 1'b0;
        // A flush wins over a new request: nothing accepted, nothing reported.
        if (ce_i && !flush_i) begin
          if (pc_i[1:0] == 2'b00) begin
            req_nxt   = 1'b1;
            addr_nxt  = pc_i;
            drop_nxt  = 1'b0;
            state_nxt = WAIT;
`ifdef FETCH_TIMEOUT_EN
            cnt_nxt   = '0;
`endif
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      WAIT: begin
        if (mem_ack_i) begin
          req_nxt  = 1'b0;
          drop_nxt = 1'b0;
          // Data belonging to a flushed path is swallowed, including a flush in the ack cycle.
          if (drop || flush_i) begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
          end else begin
            inst_nxt      = mem_rdata_i;
            inst_addr_nxt = mem_addr_o;
            valid_nxt     = 1'b1;
            state_nxt     = stall_i ? HOLD : IDLE;
          end
        end else begin
          // The bus transaction cannot be cancelled, so remember to discard its data.
          if (flush_i) begin
            drop_nxt = 1'b1;
          end
`ifdef FETCH_TIMEOUT_EN
          if (timeout_hit) begin
            req_nxt   = 1'b0;
            err_nxt   = 1'b1;
            drop_nxt  = 1'b0;
            valid_nxt = 1'b0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
`endif
        end
      end
      HOLD: begin
        // Decode took the instruction, or the path was flushed under the stall.
        if (flush_i || !stall_i) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        req_nxt   = 1'b0;
        valid_nxt = 1'b0;
        drop_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Output and bookkeeping registers; reset drops an in-flight request immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      inst_o       <= '0;
      inst_addr_o  <= '0;
      inst_valid_o <= 1'b0;
      fetch_err_o  <= 1'b0;
      drop         <= 1'b0;
    end else begin
      mem_req_o    <= req_nxt;
      mem_addr_o   <= addr_nxt;
      inst_o       <= inst_nxt;
      inst_addr_o  <= inst_addr_nxt;
      inst_valid_o <= valid_nxt;
      fetch_err_o  <= err_nxt;
      drop         <= drop_nxt;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Cycles spent in WAIT without an acknowledge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Directed bench for inst_fetch_resp: per-cycle vector table plus hand-written reset and timeout sequences.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_inst_fetch_resp;

  localparam int AW = `ADDR_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pc = '0;
  logic          ce = 1'b0;
  logic          busy;
  logic          flush = 1'b0;
  logic          stall = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [31:0]   inst;
  logic [AW-1:0] inst_addr;
  logic          inst_valid;
  logic          fetch_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  inst_fetch_resp #(.TIMEOUT(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .pc_i        (pc),
    .ce_i        (ce),
    .busy_o      (busy),
    .flush_i     (flush),
    .stall_i     (stall),
    .mem_req_o   (mem_req),
    .mem_addr_o  (mem_addr),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack),
    .inst_o      (inst),
    .inst_addr_o (inst_addr),
    .inst_valid_o(inst_valid),
    .fetch_err_o (fetch_err)
  );

  typedef struct {
    string         name;
    logic          ce;
    logic [AW-1:0] pc;
    logic          flush;
    logic          stall;
    logic          ack;
    logic [31:0]   rdata;
    logic          busy;
    logic          req;
    logic [AW-1:0] addr;
    logic          valid;
    logic [31:0]   inst;
    logic [AW-1:0] iaddr;
    logic          err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic c, logic [AW-1:0] p, logic f, logic s, logic a,
                              logic [31:0] rd, logic eb, logic er, logic [AW-1:0] ea, logic ev,
                              logic [31:0] ei, logic [AW-1:0] eia, logic ee);
    vec_t v;
    v.name = name; v.ce = c; v.pc = p; v.flush = f; v.stall = s; v.ack = a; v.rdata = rd;
    v.busy = eb; v.req = er; v.addr = ea; v.valid = ev; v.inst = ei; v.iaddr = eia; v.err = ee;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ce = 1'b0; pc = '0; flush = 1'b0; stall = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    //          name       ce pc        fl st ak rdata          busy req addr    vld inst           iaddr   err
    vecs.push_back(mk("f100_acc",  1, 'h100, 0, 0, 0, 32'h0,        1, 1, 'h100, 0, 32'h0,        'h0,   0));
    vecs.push_back(mk("f100_wait", 0, 'h0,   0, 0, 0, 32'h0,        1, 1, 'h100, 0, 32'h0,        'h0,   0));
    vecs.push_back(mk("f100_ack",  0, 'h0,   0, 0, 1, 32'h00500093, 0, 0, 'h100, 1, 32'h00500093, 'h100, 0));
    vecs.push_back(mk("f100_done", 0, 'h0,   0, 0, 0, 32'h0,        0, 0, 'h100, 0, 32'h00500093, 'h100, 0));
    vecs.push_back(mk("mis_102",   1, 'h102, 0, 0, 0, 32'h0,        0, 0, 'h100, 0, 32'h00500093, 'h100, 1));
    vecs.push_back(mk("mis_after", 0, 'h0,   0, 0, 0, 32'h0,        0, 0, 'h100, 0, 32'h00500093, 'h100, 0));
    vecs.push_back(mk("s200_acc",  1, 'h200, 0, 0, 0, 32'h0,        1, 1, 'h200, 0, 32'h00500093, 'h100, 0));
    vecs.push_back(mk("s200_wait", 0, 'h0,   0, 0, 0, 32'h0,        1, 1, 'h200, 0, 32'h00500093, 'h100, 0));
    vecs.push_back(mk("s200_ack",  0, 'h0,   0, 1, 1, 32'h12345678, 1, 0, 'h200, 1, 32'h12345678, 'h200, 0));
    vecs.push_back(mk("s200_hld1", 0, 'h0,   0, 1, 0, 32'h0,        1, 0, 'h200, 1, 32'h12345678, 'h200, 0));
    vecs.push_back(mk("s200_hld2", 0, 'h0,   0, 1, 0, 32'h0,        1, 0, 'h200, 1, 32'h12345678, 'h200, 0));
    vecs.push_back(mk("s200_hld3", 0, 'h0,   0, 1, 0, 32'h0,        1, 0, 'h200, 1, 32'h12345678, 'h200, 0));
    vecs.push_back(mk("s200_rel",  0, 'h0,   0, 0, 0, 32'h0,        0, 0, 'h200, 0, 32'h12345678, 'h200, 0));
    vecs.push_back(mk("d300_acc",  1, 'h300, 0, 0, 0, 32'h0,        1, 1, 'h300, 0, 32'h12345678, 'h200, 0));
    vecs.push_back(mk("d300_fl",   0, 'h0,   1, 0, 0, 32'h0,        1, 1, 'h300, 0, 32'h12345678, 'h200, 0));
    vecs.push_back(mk("d300_w1",   0, 'h0,   0, 0, 0, 32'h0,        1, 1, 'h300, 0, 32'h12345678, 'h200, 0));
    vecs.push_back(mk("d300_w2",   0, 'h0,   0, 0, 0, 32'h0,        1, 1, 'h300, 0, 32'h12345678, 'h200, 0));
    vecs.push_back(mk("d300_ack",  0, 'h0,   0, 0, 1, 32'hDEADBEEF, 0, 0, 'h300, 0, 32'h12345678, 'h200, 0));
    vecs.push_back(mk("f400_acc",  1, 'h400, 0, 0, 0, 32'h0,        1, 1, 'h400, 0, 32'h12345678, 'h200, 0));
    vecs.push_back(mk("f400_ack",  0, 'h0,   0, 0, 1, 32'h00A00113, 0, 0, 'h400, 1, 32'h00A00113, 'h400, 0));
    vecs.push_back(mk("c500_acc",  1, 'h500, 0, 0, 0, 32'h0,        1, 1, 'h500, 0, 32'h00A00113, 'h400, 0));
    vecs.push_back(mk("c500_flak", 0, 'h0,   1, 0, 1, 32'h11111111, 0, 0, 'h500, 0, 32'h00A00113, 'h400, 0));
    vecs.push_back(mk("i600_flce", 1, 'h600, 1, 0, 0, 32'h0,        0, 0, 'h500, 0, 32'h00A00113, 'h400, 0));
    vecs.push_back(mk("h700_acc",  1, 'h700, 0, 0, 0, 32'h0,        1, 1, 'h700, 0, 32'h00A00113, 'h400, 0));
    vecs.push_back(mk("h700_ack",  0, 'h0,   0, 1, 1, 32'h22222222, 1, 0, 'h700, 1, 32'h22222222, 'h700, 0));
    vecs.push_back(mk("h700_fl",   0, 'h0,   1, 1, 0, 32'h0,        0, 0, 'h700, 0, 32'h22222222, 'h700, 0));
    vecs.push_back(mk("b800_acc",  1, 'h800, 0, 0, 0, 32'h0,        1, 1, 'h800, 0, 32'h22222222, 'h700, 0));
    vecs.push_back(mk("b800_ack",  1, 'h804, 0, 0, 1, 32'h33333333, 0, 0, 'h800, 1, 32'h33333333, 'h800, 0));
    vecs.push_back(mk("b804_acc",  1, 'h804, 0, 0, 0, 32'h0,        1, 1, 'h804, 0, 32'h33333333, 'h800, 0));
    vecs.push_back(mk("b804_ack",  0, 'h0,   0, 0, 1, 32'h44444444, 0, 0, 'h804, 1, 32'h44444444, 'h804, 0));
    vecs.push_back(mk("b804_done", 0, 'h0,   0, 0, 0, 32'h0,        0, 0, 'h804, 0, 32'h44444444, 'h804, 0));

    // Reset state while reset is held.
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.req", 64'(mem_req), 64'd0);
    chk("rst.addr", 64'(mem_addr), 64'd0);
    chk("rst.valid", 64'(inst_valid), 64'd0);
    chk("rst.inst", 64'(inst), 64'd0);
    chk("rst.iaddr", 64'(inst_addr), 64'd0);
    chk("rst.err", 64'(fetch_err), 64'd0);
    rst = 1'b0;

    // Table: inputs applied at the falling edge, outputs compared one full cycle later.
    foreach (vecs[i]) begin
      ce = vecs[i].ce; pc = vecs[i].pc; flush = vecs[i].flush; stall = vecs[i].stall;
      mem_ack = vecs[i].ack; mem_rdata = vecs[i].rdata;
      @(negedge clk);
      chk($sformatf("%s.busy", vecs[i].name), 64'(busy), 64'(vecs[i].busy));
      chk($sformatf("%s.req", vecs[i].name), 64'(mem_req), 64'(vecs[i].req));
      chk($sformatf("%s.addr", vecs[i].name), 64'(mem_addr), 64'(vecs[i].addr));
      chk($sformatf("%s.valid", vecs[i].name), 64'(inst_valid), 64'(vecs[i].valid));
      chk($sformatf("%s.inst", vecs[i].name), 64'(inst), 64'(vecs[i].inst));
      chk($sformatf("%s.iaddr", vecs[i].name), 64'(inst_addr), 64'(vecs[i].iaddr));
      chk($sformatf("%s.err", vecs[i].name), 64'(fetch_err), 64'(vecs[i].err));
    end
    idle_inputs();

    // Reset in the middle of WAIT drops the request at once; a late ack is ignored.
    ce = 1'b1; pc = 'h900;
    @(negedge clk);
    idle_inputs();
    chk("rstw.req_before", 64'(mem_req), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstw.req_async", 64'(mem_req), 64'd0);
    chk("rstw.busy_async", 64'(busy), 64'd0);
    chk("rstw.addr_async", 64'(mem_addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    @(negedge clk);
    idle_inputs();
    chk("rstw.late_valid", 64'(inst_valid), 64'd0);
    chk("rstw.late_inst", 64'(inst), 64'd0);
    chk("rstw.late_req", 64'(mem_req), 64'd0);
    chk("rstw.late_busy", 64'(busy), 64'd0);

`ifdef FETCH_TIMEOUT_EN
    // No acknowledge: abort at the end of the 16th WAIT cycle.
    ce = 1'b1; pc = 'hA00;
    @(negedge clk);
    idle_inputs();
    chk("tmo.req_start", 64'(mem_req), 64'd1);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 15) begin
        chk("tmo.req_c15", 64'(mem_req), 64'd1);
        chk("tmo.err_c15", 64'(fetch_err), 64'd0);
      end
    end
    chk("tmo.req_fall", 64'(mem_req), 64'd0);
    chk("tmo.err_pulse", 64'(fetch_err), 64'd1);
    chk("tmo.valid", 64'(inst_valid), 64'd0);
    chk("tmo.busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("tmo.err_end", 64'(fetch_err), 64'd0);
`else
    // Without the timeout a request waits as long as it takes.
    ce = 1'b1; pc = 'hA00;
    @(negedge clk);
    idle_inputs();
    repeat (20) @(negedge clk);
    chk("notmo.req", 64'(mem_req), 64'd1);
    chk("notmo.busy", 64'(busy), 64'd1);
    chk("notmo.err", 64'(fetch_err), 64'd0);
    mem_ack = 1'b1; mem_rdata = 32'h66666666;
    @(negedge clk);
    idle_inputs();
    chk("notmo.valid", 64'(inst_valid), 64'd1);
    chk("notmo.inst", 64'(inst), 64'h66666666);
    chk("notmo.iaddr", 64'(inst_addr), 64'hA00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
